// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Time-multiplexes a 4-digit hex value onto a single-digit seven_seg driver.
//   Owns the refresh prescaler, the digit-select counter and a double-buffered
//   display register. New values are taken through a valid/ready handshake into
//   a pending buffer and copied to the active buffer only at a frame boundary
//   (select 3 -> 0), so one pass over the digits never mixes old and new data.
//   While scanning is frozen (scan_en=0) a pending value commits on the next edge.
//
//   Optional build macro: SCAN_ZERO_BLANK_EN
//     defined   -> leading-zero blanking on digits 1..3
//     undefined -> digit_blank tied low, no zero-detect logic
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active high
//   load_valid     load_data valid this cycle
//   load_ready     pending buffer free (combinational, = !pending)
//   load_data      four hex digits, digit0 = [3:0], digit3 = [15:12]
//   scan_en        1 = scan, 0 = freeze on current digit
//   display_value  nibble of the selected digit
//   display_select selected digit index
//   digit_blank    current digit should be blanked
//   frame_done     one-cycle pulse after each frame boundary
module seven_seg_scan_ctrl #(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] load_data,
   input  logic        scan_en,
   output logic [3:0]  display_value,
   output logic [1:0]  display_select,
   output logic        digit_blank,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] PRESC_TC = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] prescaler;
   logic [15:0]      active_buf;
   logic [15:0]      pend_buf;
   logic             pending;

   logic             tick;
   logic             boundary;
   logic             accept;
   logic             commit;
   logic [1:0]       sel_next;
   logic [15:0]      active_next;
   logic [3:0]       value_next;
   logic             blank_next;

   assign load_ready = !pending;

   always_comb begin
      tick        = scan_en && (prescaler == PRESC_TC);
      boundary    = tick && (display_select == 2'd3);
      accept      = load_valid && !pending;
      // Frozen scanning cannot tear a frame, so commit right away in that case.
      commit      = pending && (boundary || !scan_en);
      sel_next    = tick ? 2'(display_select + 2'd1) : display_select;
      active_next = commit ? pend_buf : active_buf;
   end

   // Outputs are registered from the next select/active so value, select and
   // blank always change on the same edge.
   always_comb begin
      value_next = 4'd0;
      case (sel_next)
         2'd0:    value_next = active_next[3:0];
         2'd1:    value_next = active_next[7:4];
         2'd2:    value_next = active_next[11:8];
         default: value_next = active_next[15:12];
      endcase
   end

`ifdef SCAN_ZERO_BLANK_EN
   logic [3:0] dig_zero;

   always_comb begin
      dig_zero[0] = (active_next[3:0]   == 4'd0);
      dig_zero[1] = (active_next[7:4]   == 4'd0);
      dig_zero[2] = (active_next[11:8]  == 4'd0);
      dig_zero[3] = (active_next[15:12] == 4'd0);
      blank_next  = 1'b0;
      case (sel_next)
         2'd0:    blank_next = 1'b0;
         2'd1:    blank_next = dig_zero[1] && dig_zero[2] && dig_zero[3];
         2'd2:    blank_next = dig_zero[2] && dig_zero[3];
         default: blank_next = dig_zero[3];
      endcase
   end
`else
   assign blank_next = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler      <= '0;
         display_select <= 2'd0;
         active_buf     <= 16'd0;
         pend_buf       <= 16'd0;
         pending        <= 1'b0;
         display_value  <= 4'd0;
         digit_blank    <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         if (scan_en) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
         end
         display_select <= sel_next;
         active_buf     <= active_next;
         display_value  <= value_next;
         digit_blank    <= blank_next;
         frame_done     <= boundary;
         // accept only happens with pending=0, so it never collides with commit.
         if (accept) begin
            pend_buf <= load_data;
            pending  <= 1'b1;
         end else if (commit) begin
            pending  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic        scan_en;
   logic [3:0]  display_value;
   logic [1:0]  display_select;
   logic        digit_blank;
   logic        frame_done;

   seven_seg_scan_ctrl #(.REFRESH_DIV(DIV), .CNT_W(16)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .load_valid     (load_valid),
      .load_ready     (load_ready),
      .load_data      (load_data),
      .scan_en        (scan_en),
      .display_value  (display_value),
      .display_select (display_select),
      .digit_blank    (digit_blank),
      .frame_done     (frame_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: count of enabled cycles since reset gives the scan
   // position directly; a frame is 4*DIV enabled cycles.
   int unsigned n_scan;
   logic [15:0] m_active;
   logic [15:0] m_pbuf;
   bit          m_pending;
   bit          m_fd;
   bit          last_acc;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_sel();
      return int'((n_scan / DIV) % 4);
   endfunction

   function automatic logic [3:0] m_digit(input int i);
      logic [15:0] t;
      t = m_active >> (4 * i);
      return t[3:0];
   endfunction

   task automatic check_outputs();
      int s;
      logic [15:0] upper;
      bit blank;
      s = m_sel();
      upper = m_active >> (4 * s);
      blank = 1'b0;
`ifdef SCAN_ZERO_BLANK_EN
      blank = (s > 0) && (upper == 16'd0);
`endif
      check("select",     16'(display_select), 16'(s));
      check("value",      16'(display_value),  16'(m_digit(s)));
      check("blank",      16'(digit_blank),    16'(blank));
      check("frame_done", 16'(frame_done),     16'(m_fd));
      check("load_ready", 16'(load_ready),     16'(!m_pending));
   endtask

   task automatic model_reset();
      n_scan    = 0;
      m_active  = 16'd0;
      m_pbuf    = 16'd0;
      m_pending = 1'b0;
      m_fd      = 1'b0;
      last_acc  = 1'b0;
   endtask

   // Called at a negedge with inputs already driven.
   task automatic step();
      bit acc, bnd;
      acc = load_valid && !m_pending;
      @(posedge clk);
      bnd = 1'b0;
      if (scan_en) begin
         n_scan++;
         bnd = ((n_scan % (4 * DIV)) == 0);
      end
      if (m_pending && (bnd || !scan_en)) begin
         m_active  = m_pbuf;
         m_pending = 1'b0;
      end
      if (acc) begin
         m_pbuf    = load_data;
         m_pending = 1'b1;
      end
      m_fd     = bnd;
      last_acc = acc;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_accept(input logic [15:0] d);
      int k;
      load_valid = 1'b1;
      load_data  = d;
      k = 0;
      do begin
         step();
         k++;
      end while (!last_acc && k < 200);
      if (!last_acc) check("accept_timeout", 16'd0, 16'd1);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      model_reset();
      check_outputs();
      @(negedge clk);
      check_outputs();
      rst = 1'b0;
   endtask

   initial begin
      int k;
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = 16'd0;
      scan_en    = 1'b1;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      check_outputs();
      rst = 1'b0;

      // free-running scan: select steps every DIV, frame_done every 4*DIV
      steps(40);

      // single load mid-frame
      steps(6);
      wait_accept(16'h1234);
      load_valid = 1'b0;
      steps(40);

      // back-to-back loads with load_valid held
      wait_accept(16'h1234);
      wait_accept(16'h5678);
      load_valid = 1'b0;
      steps(40);

      // freeze at select 2 and load while frozen
      k = 0;
      while (m_sel() != 2 && k < 100) begin step(); k++; end
      check("reach_sel2", 16'(m_sel()), 16'd2);
      scan_en = 1'b0;
      wait_accept(16'hABCD);
      load_valid = 1'b0;
      steps(6);
      scan_en = 1'b1;
      steps(24);

      // reset mid-frame with a load pending
      wait_accept(16'h9999);
      load_valid = 1'b0;
      steps(2);
      check("pending_before_rst", 16'(load_ready), 16'd0);
      pulse_reset();
      steps(40);

      // leading-zero patterns
      wait_accept(16'h0042);
      load_valid = 1'b0;
      steps(40);
      wait_accept(16'h0000);
      load_valid = 1'b0;
      steps(40);
      wait_accept(16'h0700);
      load_valid = 1'b0;
      steps(40);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         load_valid = ($urandom_range(0, 99) < 30);
         load_data  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255))
                                                  : 16'($urandom);
         scan_en    = ($urandom_range(0, 99) < 85);
         if ($urandom_range(0, 999) == 0) begin
            pulse_reset();
         end else begin
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Scan controller that time-multiplexes a 4-digit hex value onto the single-digit seven_seg driver through its display_value/display_select inputs. It owns a refresh prescaler, a digit-select counter and a double-buffered display register. Loads are accepted through a valid/ready handshake and committed only at a frame boundary, so a digit pass never shows a mix of old and new digits. Sits between the system-side value producer and seven_seg.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit is held; legal range >= 1.
CNT_W, 16, prescaler width; must satisfy 2**CNT_W >= REFRESH_DIV.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
load_valid  input  1  load_data is valid this cycle
load_ready  output  1  pending buffer free; a load is accepted when load_valid && load_ready
load_data  input  16  four hex digits; digit0 = [3:0], digit3 = [15:12]
scan_en  input  1  1 = scan digits, 0 = freeze on current digit
display_value  output  4  nibble for the selected digit, to seven_seg
display_select  output  2  selected digit index, to seven_seg
digit_blank  output  1  1 = current digit should be blanked (see Optional Feature)
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async, rst=1): prescaler=0, display_select=0, active buffer=0, pending buffer=0, pending flag=0, display_value=0, digit_blank=0, frame_done=0. load_ready=1 while rst is low and pending=0. Asserting rst mid-frame discards any pending load.
- load_ready = !pending (combinational). An accepted load writes the pending buffer and sets pending on the same edge. load_ready is 0 from the next cycle. No overwrite is possible while pending=1.
- Prescaler: while scan_en=1, counts 0..REFRESH_DIV-1 and wraps to 0. tick = scan_en && (prescaler == REFRESH_DIV-1). With REFRESH_DIV=1, tick is asserted every scan_en cycle.
- On tick: display_select increments mod 4 (3 -> 0).
- Frame boundary = tick while display_select==3.
  - frame_done=1 for exactly that following cycle.
  - If pending=1: active <= pending buffer and pending <= 0 on the same edge. load_ready returns to 1 on the next cycle.
- scan_en=0:
  - Prescaler and display_select hold.
  - frame_done stays 0.
  - A pending value commits to active on the next clock edge, since there is no tearing risk while frozen.
  - Raising scan_en again resumes counting from the held prescaler value.
- display_value and digit_blank are registers. They are updated on the same edge as display_select, computed from the next select index and next active buffer, so the three outputs always agree.
  - Latency: at a frame-boundary commit, the new digit0 appears together with display_select=0.
  - With scan_en=0, a load is visible two edges after acceptance: one edge to pending, one edge to commit and output.
- Simultaneous load and boundary with pending=0: the load goes to the pending buffer only and commits at the next frame boundary, or on the next edge if scan_en=0.

Optional Feature:
SCAN_ZERO_BLANK_EN
- Defined: leading-zero blanking. For the selected digit i>0, digit_blank=1 when active digits i..3 are all zero. Digit 0 is never blanked.
- Undefined: digit_blank is constant 0 and the zero-detect logic is not built.

Test Plan:
- Reset with REFRESH_DIV=4: rst=1 -> display_value=0, display_select=0, frame_done=0, load_ready=1. Release -> display_select steps 0,1,2,3,0 every 4 cycles; frame_done pulses every 16 cycles.
- Load 0x1234 mid-frame, scan_en=1 -> load_ready=0 until the boundary. After the boundary, select 0/1/2/3 shows 4/3/2/1, each for 4 cycles. load_ready=1 again one cycle after the commit.
- Back-to-back loads 0x1234 then 0x5678 (load_valid held) -> second load stalls until load_ready rises after the first commit. 0x5678 is shown from the following frame, never mixed with 0x1234 within one frame.
- scan_en=0 at select=2, load 0xABCD -> select stays 2, prescaler frozen; display_value=0xB two edges after acceptance. Re-enable -> scanning resumes from the held count.
- rst pulse mid-frame while pending=1 -> all outputs 0 immediately. After release, active=0 and the pending value is lost.
- With SCAN_ZERO_BLANK_EN defined:
  - Load 0x0042 -> digit_blank=1 on selects 2,3 and 0 on selects 0,1.
  - Load 0x0000 -> blank on selects 1..3; select 0 shows 0 unblanked.
  - Without the macro, digit_blank=0 always.
